// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch sequencing controller.
// Contents:
//   STATE_W    - state encoding width (3 bits, fixed even without the alarm)
//   TIME_W_DEF - default width of timer count / display value (10 ms units)
//   state_t    - controller state enum
//   sat_sub    - saturating subtract used for the countdown display
package stopwatch_pkg;

    localparam int STATE_W    = 3;
    localparam int TIME_W_DEF = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LAP   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    // a - b, clamped at zero so an overrun countdown never wraps.
    function automatic logic [TIME_W_DEF-1:0] sat_sub(
        input logic [TIME_W_DEF-1:0] i_a,
        input logic [TIME_W_DEF-1:0] i_b
    );
        return (i_a > i_b) ? (i_a - i_b) : '0;
    endfunction

endpackage

// File: rtl/stopwatch_alarm_blinker.sv
// alarm_blinker: alarm output toggler for the stopwatch countdown expiry.
// While i_en is high the output goes to 1 on the first enabled cycle and then
// toggles every BLINK_DIV cycles. Dropping i_en clears the output and counter
// on the next edge.
// Ports:
//   clock   - system clock
//   reset   - asynchronous, active-high reset
//   i_en    - blink enable
//   o_blink - registered blink output
module alarm_blinker #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    output logic o_blink
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_blink;

    // Down-counter reloaded with BLINK_DIV-1; terminal count toggles output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_blink <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_blink <= 1'b0;
        end else if (!r_armed) begin
            r_armed <= 1'b1;
            r_blink <= 1'b1;
            r_cnt   <= RELOAD;
        end else if (r_cnt == '0) begin
            r_blink <= ~r_blink;
            r_cnt   <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_blink = r_blink;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequencing controller for the 10 ms stopwatch timer.
// Turns one-cycle key pulses into the timer's active-low clear/stop controls,
// handles lap capture, up/countdown display and countdown expiry.
// Build option: STOPWATCH_ALARM_EN - when defined, expiry enters ALARM and the
// alarm output blinks; when undefined, expiry goes to PAUSE and alarm is 0.
// Ports:
//   clock, reset           - system clock, asynchronous active-high reset
//   key_start/lap/clr/mode - one-cycle key pulses (priority clr>start>lap>mode)
//   time_10ms              - live timer count
//   tmr_clear_n, tmr_run_n - timer clear (0 = clear) and stop (0 = hold)
//   tmr_up                 - timer count direction, constant 1
//   disp_value             - display value, one cycle behind its source
//   mode_down              - 1 = countdown display
//   lap_count              - laps captured, saturating
//   state_o                - current state encoding
//   alarm                  - blinking alarm output
//
// state | meaning
// IDLE  | timer held in clear; mode key active; start needs count == 0
// RUN   | timer counting, display live
// LAP   | timer counting, display frozen on captured lap
// PAUSE | timer held; display keeps whatever source it had
// ALARM | countdown expired, timer held, alarm blinking
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W    = TIME_W_DEF,
    parameter int PRESET    = 6000,
    parameter int BLINK_DIV = 25000000,
    parameter int LAP_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_start,
    input  logic              key_lap,
    input  logic              key_clr,
    input  logic              key_mode,
    input  logic [TIME_W-1:0] time_10ms,
    output logic              tmr_clear_n,
    output logic              tmr_run_n,
    output logic              tmr_up,
    output logic [TIME_W-1:0] disp_value,
    output logic              mode_down,
    output logic [LAP_W-1:0]  lap_count,
    output logic [2:0]        state_o,
    output logic              alarm
);

    localparam logic [TIME_W-1:0] W_PRESET = TIME_W'(PRESET);

    state_t            r_state;
    logic              r_tmr_clear_n;
    logic              r_tmr_run_n;
    logic              r_tmr_up;
    logic [TIME_W-1:0] r_disp;
    logic              r_mode_down;
    logic [LAP_W-1:0]  r_lap_count;
    logic [TIME_W-1:0] r_lap;
    logic              r_show_lap;

    logic              w_k_clr;
    logic              w_k_start;
    logic              w_k_lap;
    logic              w_k_mode;
    logic              w_expire;
    logic [TIME_W-1:0] w_src;
    logic [TIME_W-1:0] w_disp_next;

    // Only the highest-priority pulse in a cycle acts.
    assign w_k_clr   = key_clr;
    assign w_k_start = key_start & ~key_clr;
    assign w_k_lap   = key_lap & ~key_start & ~key_clr;
    assign w_k_mode  = key_mode & ~key_lap & ~key_start & ~key_clr;

    assign w_expire = ((r_state == ST_RUN) || (r_state == ST_LAP)) &&
                      r_mode_down && (time_10ms >= W_PRESET);

    assign w_src       = r_show_lap ? r_lap : time_10ms;
    // sat_sub works at the package width; TIME_W must not exceed it.
    assign w_disp_next = r_mode_down ?
                         TIME_W'(sat_sub(TIME_W_DEF'(W_PRESET), TIME_W_DEF'(w_src))) :
                         w_src;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tmr_clear_n <= 1'b0;
            r_tmr_run_n   <= 1'b0;
            r_tmr_up      <= 1'b1;
            r_disp        <= '0;
            r_mode_down   <= 1'b0;
            r_lap_count   <= '0;
            r_lap         <= '0;
            r_show_lap    <= 1'b0;
        end else begin
            r_tmr_up <= 1'b1;
            r_disp   <= w_disp_next;

            // Timer controls follow the state, so they lag a transition by a cycle.
            case (r_state)
                ST_IDLE: begin
                    r_tmr_clear_n <= 1'b0;
                    r_tmr_run_n   <= 1'b0;
                end
                ST_RUN, ST_LAP: begin
                    r_tmr_clear_n <= 1'b1;
                    r_tmr_run_n   <= 1'b1;
                end
                default: begin
                    r_tmr_clear_n <= 1'b1;
                    r_tmr_run_n   <= 1'b0;
                end
            endcase

            case (r_state)
                ST_IDLE: begin
                    // A nonzero count means the timer has not yet taken the clear.
                    if (w_k_start && (time_10ms == '0)) begin
                        r_state    <= ST_RUN;
                        r_show_lap <= 1'b0;
                    end else if (w_k_mode) begin
                        r_mode_down <= ~r_mode_down;
                    end
                end
                ST_RUN: begin
                    if (w_expire) begin
`ifdef STOPWATCH_ALARM_EN
                        r_state <= ST_ALARM;
`else
                        r_state <= ST_PAUSE;
`endif
                        r_show_lap <= 1'b0;
                    end else if (w_k_start) begin
                        r_state <= ST_PAUSE;
                    end else if (w_k_lap) begin
                        r_state    <= ST_LAP;
                        r_lap      <= time_10ms;
                        r_show_lap <= 1'b1;
                        if (r_lap_count != '1) begin
                            r_lap_count <= r_lap_count + LAP_W'(1);
                        end
                    end
                end
                ST_LAP: begin
                    if (w_expire) begin
`ifdef STOPWATCH_ALARM_EN
                        r_state <= ST_ALARM;
`else
                        r_state <= ST_PAUSE;
`endif
                        r_show_lap <= 1'b0;
                    end else if (w_k_start) begin
                        // Display stays on the lap value while paused.
                        r_state <= ST_PAUSE;
                    end else if (w_k_lap) begin
                        r_state    <= ST_RUN;
                        r_show_lap <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (w_k_clr) begin
                        r_state     <= ST_IDLE;
                        r_lap_count <= '0;
                        r_show_lap  <= 1'b0;
                    end else if (w_k_start) begin
                        r_state    <= ST_RUN;
                        r_show_lap <= 1'b0;
                    end
                end
`ifdef STOPWATCH_ALARM_EN
                ST_ALARM: begin
                    if (key_clr || key_start || key_lap || key_mode) begin
                        r_state     <= ST_IDLE;
                        r_lap_count <= '0;
                        r_show_lap  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state     <= ST_IDLE;
                    r_lap_count <= '0;
                    r_show_lap  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_ALARM_EN
    logic w_alarm_en;
    logic w_alarm;

    // Dropping the enable on the leaving key clears alarm on the same edge
    // that the state returns to IDLE.
    assign w_alarm_en = (r_state == ST_ALARM) &&
                        !(key_clr || key_start || key_lap || key_mode);

    alarm_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_alarm_blinker (
        .clock   (clock),
        .reset   (reset),
        .i_en    (w_alarm_en),
        .o_blink (w_alarm)
    );

    assign alarm = w_alarm;
`else
    assign alarm = 1'b0;
`endif

    assign tmr_clear_n = r_tmr_clear_n;
    assign tmr_run_n   = r_tmr_run_n;
    assign tmr_up      = r_tmr_up;
    assign disp_value  = r_disp;
    assign mode_down   = r_mode_down;
    assign lap_count   = r_lap_count;
    assign state_o     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int TIME_W    = 32;
    localparam int PRESET    = 6000;
    localparam int BLINK_DIV = 8;
    localparam int LAP_W     = 4;

`ifdef STOPWATCH_ALARM_EN
    localparam logic [2:0] EXP_STATE = 3'd4;
`else
    localparam logic [2:0] EXP_STATE = 3'd3;
`endif

    logic              clock;
    logic              reset;
    logic              key_start, key_lap, key_clr, key_mode;
    logic [TIME_W-1:0] time_10ms;
    logic              tmr_clear_n, tmr_run_n, tmr_up;
    logic [TIME_W-1:0] disp_value;
    logic              mode_down;
    logic [LAP_W-1:0]  lap_count;
    logic [2:0]        state_o;
    logic              alarm;

    int n_tests = 0;
    int n_fail  = 0;
    logic [TIME_W-1:0] exp_q[$];
    logic [TIME_W-1:0] exp_v;

    stopwatch_ctrl #(
        .TIME_W    (TIME_W),
        .PRESET    (PRESET),
        .BLINK_DIV (BLINK_DIV),
        .LAP_W     (LAP_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_start   (key_start),
        .key_lap     (key_lap),
        .key_clr     (key_clr),
        .key_mode    (key_mode),
        .time_10ms   (time_10ms),
        .tmr_clear_n (tmr_clear_n),
        .tmr_run_n   (tmr_run_n),
        .tmr_up      (tmr_up),
        .disp_value  (disp_value),
        .mode_down   (mode_down),
        .lap_count   (lap_count),
        .state_o     (state_o),
        .alarm       (alarm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        key_start = 1'b1; tick(); key_start = 1'b0;
    endtask
    task automatic pulse_lap();
        key_lap = 1'b1; tick(); key_lap = 1'b0;
    endtask
    task automatic pulse_clr();
        key_clr = 1'b1; tick(); key_clr = 1'b0;
    endtask
    task automatic pulse_mode();
        key_mode = 1'b1; tick(); key_mode = 1'b0;
    endtask

    function automatic logic [TIME_W-1:0] disp_model(input logic [TIME_W-1:0] src,
                                                     input logic down);
        if (!down) return src;
        return (src < TIME_W'(PRESET)) ? TIME_W'(PRESET) - src : '0;
    endfunction

    // One display sample: drive the source, expect the model value after the edge.
    task automatic disp_step(input logic [TIME_W-1:0] t, input logic [TIME_W-1:0] src,
                             input logic down, input string name);
        time_10ms = t;
        exp_q.push_back(disp_model(src, down));
        tick();
        exp_v = exp_q.pop_front();
        n_tests++;
        if (disp_value !== exp_v) begin
            n_fail++;
            $display("FAIL %s: disp_value got %0d expected %0d", name, disp_value, exp_v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_tests++;
        if (state_o !== 3'd0 || tmr_clear_n !== 1'b0 || tmr_run_n !== 1'b0 || tmr_up !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: state=%0d clr_n=%b run_n=%b up=%b expected 0/0/0/1",
                     state_o, tmr_clear_n, tmr_run_n, tmr_up);
        end
        n_tests++;
        if (disp_value !== '0 || mode_down !== 1'b0 || lap_count !== '0 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: disp=%0d mode=%b lap=%0d alarm=%b expected all 0",
                     disp_value, mode_down, lap_count, alarm);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_start();
        time_10ms = '0;
        pulse_start();
        n_tests++;
        if (state_o !== 3'd1 || tmr_clear_n !== 1'b0) begin
            n_fail++;
            $display("FAIL start_state: state=%0d clr_n=%b expected 1/0", state_o, tmr_clear_n);
        end
        tick();
        n_tests++;
        if (tmr_clear_n !== 1'b1 || tmr_run_n !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ctrl: clr_n=%b run_n=%b expected 1/1", tmr_clear_n, tmr_run_n);
        end
    endtask

    task automatic test_lap();
        disp_step(32'd1234, 32'd1234, 1'b0, "lap_live");
        key_lap = 1'b1;
        disp_step(32'd1234, 32'd1234, 1'b0, "lap_capture_edge");
        key_lap = 1'b0;
        n_tests++;
        if (state_o !== 3'd2 || lap_count !== 4'd1) begin
            n_fail++;
            $display("FAIL lap_capture: state=%0d lap=%0d expected 2/1", state_o, lap_count);
        end
        disp_step(32'd1300, 32'd1234, 1'b0, "lap_frozen1");
        disp_step(32'd1300, 32'd1234, 1'b0, "lap_frozen2");
        key_lap = 1'b1;
        disp_step(32'd1300, 32'd1234, 1'b0, "lap_release_edge");
        key_lap = 1'b0;
        n_tests++;
        if (state_o !== 3'd1 || lap_count !== 4'd1) begin
            n_fail++;
            $display("FAIL lap_release: state=%0d lap=%0d expected 1/1", state_o, lap_count);
        end
        disp_step(32'd1300, 32'd1300, 1'b0, "lap_tracking");
        disp_step(32'd1310, 32'd1310, 1'b0, "lap_tracking2");
    endtask

    task automatic test_pause_clear();
        pulse_start();
        n_tests++;
        if (state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL pause_enter: state=%0d expected 3", state_o);
        end
        tick();
        n_tests++;
        if (tmr_run_n !== 1'b0 || tmr_clear_n !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_ctrl: run_n=%b clr_n=%b expected 0/1", tmr_run_n, tmr_clear_n);
        end
        pulse_clr();
        n_tests++;
        if (state_o !== 3'd0 || lap_count !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_idle: state=%0d lap=%0d expected 0/0", state_o, lap_count);
        end
        tick();
        n_tests++;
        if (tmr_clear_n !== 1'b0 || tmr_run_n !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ctrl: clr_n=%b run_n=%b expected 0/0", tmr_clear_n, tmr_run_n);
        end
        time_10ms = 32'd57;
        pulse_start();
        n_tests++;
        if (state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL start_pending_clear: state=%0d expected 0", state_o);
        end
        time_10ms = '0;
        tick();
        pulse_start();
        n_tests++;
        if (state_o !== 3'd1) begin
            n_fail++;
            $display("FAIL start_after_clear: state=%0d expected 1", state_o);
        end
    endtask

    task automatic test_coincide_pause();
        pulse_start();
        key_clr = 1'b1; key_start = 1'b1;
        tick();
        key_clr = 1'b0; key_start = 1'b0;
        n_tests++;
        if (state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL clr_beats_start: state=%0d expected 0", state_o);
        end
        tick();
    endtask

    task automatic test_mode_down();
        time_10ms = '0;
        pulse_mode();
        n_tests++;
        if (mode_down !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_toggle: mode_down=%b expected 1", mode_down);
        end
        pulse_start();
        pulse_mode();
        n_tests++;
        if (mode_down !== 1'b1 || state_o !== 3'd1) begin
            n_fail++;
            $display("FAIL mode_ignored_run: mode=%b state=%0d expected 1/1", mode_down, state_o);
        end
        disp_step(32'd1000, 32'd1000, 1'b1, "countdown_1000");
        disp_step(32'd6000, 32'd6000, 1'b1, "countdown_expire");
        n_tests++;
        if (state_o !== EXP_STATE) begin
            n_fail++;
            $display("FAIL expire_state: state=%0d expected %0d", state_o, EXP_STATE);
        end
        tick();
        n_tests++;
        if (tmr_run_n !== 1'b0) begin
            n_fail++;
            $display("FAIL expire_hold: run_n=%b expected 0", tmr_run_n);
        end
        disp_step(32'd6005, 32'd6005, 1'b1, "countdown_overrun");
`ifdef STOPWATCH_ALARM_EN
        repeat (6) tick();
        n_tests++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_high: alarm=%b expected 1", alarm);
        end
        tick();
        n_tests++;
        if (alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_toggle: alarm=%b expected 0", alarm);
        end
        repeat (8) tick();
        n_tests++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_toggle2: alarm=%b expected 1", alarm);
        end
        pulse_lap();
        n_tests++;
        if (state_o !== 3'd0 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_exit: state=%0d alarm=%b expected 0/0", state_o, alarm);
        end
`else
        n_tests++;
        if (alarm !== 1'b0 || state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL no_alarm: alarm=%b state=%0d expected 0/3", alarm, state_o);
        end
        pulse_clr();
        n_tests++;
        if (state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL expire_exit: state=%0d expected 0", state_o);
        end
`endif
        time_10ms = '0;
        tick();
    endtask

    task automatic test_expire_lap();
        pulse_start();
        time_10ms = 32'd100;
        pulse_lap();
        pulse_lap();
        n_tests++;
        if (state_o !== 3'd1 || lap_count !== 4'd1) begin
            n_fail++;
            $display("FAIL pre_expire: state=%0d lap=%0d expected 1/1", state_o, lap_count);
        end
        time_10ms = 32'd6000;
        pulse_lap();
        n_tests++;
        if (state_o !== EXP_STATE || lap_count !== 4'd1) begin
            n_fail++;
            $display("FAIL expire_beats_lap: state=%0d lap=%0d expected %0d/1",
                     state_o, lap_count, EXP_STATE);
        end
        pulse_clr();
        time_10ms = '0;
        tick();
        pulse_mode();
        n_tests++;
        if (state_o !== 3'd0 || mode_down !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_back_up: state=%0d mode=%b expected 0/0", state_o, mode_down);
        end
    endtask

    task automatic test_lap_saturate();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            time_10ms = TIME_W'(10 * (i + 1));
            pulse_lap();
            pulse_lap();
        end
        n_tests++;
        if (lap_count !== 4'd15 || state_o !== 3'd1) begin
            n_fail++;
            $display("FAIL lap_saturate: lap=%0d state=%0d expected 15/1", lap_count, state_o);
        end
        pulse_start();
        pulse_clr();
        time_10ms = '0;
        tick();
    endtask

    task automatic test_async_reset();
        pulse_mode();
        pulse_start();
        time_10ms = 32'd50;
        pulse_lap();
        tick();
        n_tests++;
        if (state_o !== 3'd2 || disp_value !== 32'd5950 || tmr_run_n !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: state=%0d disp=%0d run_n=%b expected 2/5950/1",
                     state_o, disp_value, tmr_run_n);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (state_o !== 3'd0 || tmr_clear_n !== 1'b0 || tmr_run_n !== 1'b0 || tmr_up !== 1'b1 ||
            disp_value !== '0 || mode_down !== 1'b0 || lap_count !== '0 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d clr_n=%b run_n=%b up=%b disp=%0d mode=%b lap=%0d alarm=%b",
                     state_o, tmr_clear_n, tmr_run_n, tmr_up, disp_value, mode_down, lap_count, alarm);
        end
        time_10ms = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        key_start = 1'b0;
        key_lap   = 1'b0;
        key_clr   = 1'b0;
        key_mode  = 1'b0;
        time_10ms = '0;
        test_reset();
        test_start();
        test_lap();
        test_pause_clear();
        test_coincide_pause();
        test_mode_down();
        test_expire_lap();
        test_lap_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
